// File: rtl/leaf_pkg.sv
// Shared widths and field layouts for the BFT leaf output path: the per-port
// control-register slice and the outbound packet format.
package leaf_pkg;

  localparam int DEF_PACKET_BITS   = 97;
  localparam int DEF_NUM_LEAF_BITS = 6;
  localparam int DEF_NUM_PORT_BITS = 4;
  localparam int DEF_NUM_ADDR_BITS = 7;
  localparam int DEF_PAYLOAD_BITS  = 64;
  localparam int DEF_NUM_OUT_PORTS = 7;

  // Per-port control slice, LSB first:
  // freespace, bram_addr, dst_port, dst_leaf, add_fs_en, upd_addr_en, upd_fs_en.
  localparam int SL_FS_LSB   = 0;
  localparam int SL_ADDR_LSB = SL_FS_LSB + DEF_NUM_ADDR_BITS;
  localparam int SL_PORT_LSB = SL_ADDR_LSB + DEF_NUM_ADDR_BITS;
  localparam int SL_LEAF_LSB = SL_PORT_LSB + DEF_NUM_PORT_BITS;
  localparam int SL_ADD_BIT  = SL_LEAF_LSB + DEF_NUM_LEAF_BITS;
  localparam int SL_UPDA_BIT = SL_ADD_BIT + 1;
  localparam int SL_UPDF_BIT = SL_UPDA_BIT + 1;
  localparam int SLICE_BITS  = SL_UPDF_BIT + 1;

  // Outbound packet fields.
  localparam int PKT_VALID_BIT   = DEF_PACKET_BITS - 1;
  localparam int PKT_LEAF_LSB    = PKT_VALID_BIT - DEF_NUM_LEAF_BITS;
  localparam int PKT_PORT_LSB    = PKT_LEAF_LSB - DEF_NUM_PORT_BITS;
  localparam int PKT_ADDR_LSB    = DEF_PAYLOAD_BITS;
  localparam int PKT_PAYLOAD_LSB = 0;

endpackage

// File: rtl/leaf_out_arbiter_if.sv
// Bundle of the port-side and packet-side signals of the leaf output arbiter.
interface leaf_out_arbiter_if import leaf_pkg::*; #(
  parameter int PACKET_BITS   = DEF_PACKET_BITS,
  parameter int NUM_LEAF_BITS = DEF_NUM_LEAF_BITS,
  parameter int NUM_PORT_BITS = DEF_NUM_PORT_BITS,
  parameter int NUM_ADDR_BITS = DEF_NUM_ADDR_BITS,
  parameter int PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
  parameter int NUM_OUT_PORTS = DEF_NUM_OUT_PORTS
);
  localparam int OUT_PORTS_REG_BITS = NUM_LEAF_BITS + NUM_PORT_BITS + 2*NUM_ADDR_BITS + 3;

  // Handshakes: a port word moves when i_valid[k] && o_ready[k] in one cycle;
  // a packet moves when o_packet_valid && i_packet_ready in one cycle.
  logic [OUT_PORTS_REG_BITS*NUM_OUT_PORTS-1:0] i_out_ctrl;
  logic [PAYLOAD_BITS*NUM_OUT_PORTS-1:0]       i_data;
  logic [NUM_OUT_PORTS-1:0]                    i_valid;
  logic [NUM_OUT_PORTS-1:0]                    o_ready;
  logic [PACKET_BITS-1:0]                      o_packet;
  logic                                        o_packet_valid;
  logic                                        i_packet_ready;

  modport master (
    output i_out_ctrl, i_data, i_valid, i_packet_ready,
    input  o_ready, o_packet, o_packet_valid
  );

  modport slave (
    input  i_out_ctrl, i_data, i_valid, i_packet_ready,
    output o_ready, o_packet, o_packet_valid
  );
endinterface

// File: rtl/leaf_out_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 7,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic found;
    int   j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Per-port credit/address tracking and round-robin launch of port words onto
// the leaf's single outbound packet stream through a one-entry output register.
module leaf_out_arbiter import leaf_pkg::*; #(
  parameter int PACKET_BITS   = DEF_PACKET_BITS,
  parameter int NUM_LEAF_BITS = DEF_NUM_LEAF_BITS,
  parameter int NUM_PORT_BITS = DEF_NUM_PORT_BITS,
  parameter int NUM_ADDR_BITS = DEF_NUM_ADDR_BITS,
  parameter int PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
  parameter int NUM_OUT_PORTS = DEF_NUM_OUT_PORTS
) (
  input logic               clk,
  input logic               reset_n,
  leaf_out_arbiter_if.slave bus
);

  localparam int OUT_PORTS_REG_BITS = NUM_LEAF_BITS + NUM_PORT_BITS + 2*NUM_ADDR_BITS + 3;
  localparam int S        = OUT_PORTS_REG_BITS;
  localparam int IDX_BITS = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

  localparam int C_FS_LSB   = 0;
  localparam int C_ADDR_LSB = C_FS_LSB + NUM_ADDR_BITS;
  localparam int C_PORT_LSB = C_ADDR_LSB + NUM_ADDR_BITS;
  localparam int C_LEAF_LSB = C_PORT_LSB + NUM_PORT_BITS;
  localparam int C_ADD_BIT  = C_LEAF_LSB + NUM_LEAF_BITS;
  localparam int C_UPDA_BIT = C_ADD_BIT + 1;
  localparam int C_UPDF_BIT = C_UPDA_BIT + 1;

  localparam int P_LEAF_LSB = PACKET_BITS - 1 - NUM_LEAF_BITS;
  localparam int P_PORT_LSB = P_LEAF_LSB - NUM_PORT_BITS;

  localparam logic [NUM_ADDR_BITS-1:0] CREDIT_MAX = '1;

  logic [NUM_OUT_PORTS-1:0] upd_fs, upd_addr, add_fs, elig, grant, fire;
  logic [NUM_ADDR_BITS-1:0] fs_val   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_val [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] dst_leaf [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dst_port [NUM_OUT_PORTS];
  logic [PAYLOAD_BITS-1:0]  payload  [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] credit_q [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];

  logic [IDX_BITS-1:0]    rr_ptr_q, grant_idx;
  logic [PACKET_BITS-1:0] pkt_q, pkt_d;
  logic                   vld_q, slot_free, any_fire;

  // A port being reconfigured this cycle sits out of arbitration.
  for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_port
    assign upd_fs[k]   = bus.i_out_ctrl[k*S + C_UPDF_BIT];
    assign upd_addr[k] = bus.i_out_ctrl[k*S + C_UPDA_BIT];
    assign add_fs[k]   = bus.i_out_ctrl[k*S + C_ADD_BIT];
    assign fs_val[k]   = bus.i_out_ctrl[k*S + C_FS_LSB   +: NUM_ADDR_BITS];
    assign addr_val[k] = bus.i_out_ctrl[k*S + C_ADDR_LSB +: NUM_ADDR_BITS];
    assign dst_port[k] = bus.i_out_ctrl[k*S + C_PORT_LSB +: NUM_PORT_BITS];
    assign dst_leaf[k] = bus.i_out_ctrl[k*S + C_LEAF_LSB +: NUM_LEAF_BITS];
    assign payload[k]  = bus.i_data[k*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign elig[k]     = bus.i_valid[k] && (credit_q[k] != '0) && !upd_fs[k] && !upd_addr[k];
  end

  rr_arbiter #(.N(NUM_OUT_PORTS), .IW(IDX_BITS)) u_rr (
    .req   (elig),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign slot_free   = !vld_q || bus.i_packet_ready;
  assign fire        = (reset_n && slot_free) ? grant : '0;
  assign any_fire    = |fire;
  assign bus.o_ready = fire;

  always_comb begin
    pkt_d = '0;
    pkt_d[PACKET_BITS-1]                      = 1'b1;
    pkt_d[P_LEAF_LSB +: NUM_LEAF_BITS]        = dst_leaf[grant_idx];
    pkt_d[P_PORT_LSB +: NUM_PORT_BITS]        = dst_port[grant_idx];
    pkt_d[PAYLOAD_BITS +: NUM_ADDR_BITS]      = addr_q[grant_idx];
    pkt_d[PAYLOAD_BITS-1:0]                   = payload[grant_idx];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_OUT_PORTS; k++) begin
        credit_q[k] <= '0;
        addr_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_OUT_PORTS; k++) begin
        // Add and fire together cancel out.
        if (upd_fs[k])                  credit_q[k] <= fs_val[k];
        else if (add_fs[k] && fire[k])  credit_q[k] <= credit_q[k];
        else if (add_fs[k]) begin
          if (credit_q[k] != CREDIT_MAX) credit_q[k] <= credit_q[k] + 1'b1;
        end
        else if (fire[k])               credit_q[k] <= credit_q[k] - 1'b1;

        if (upd_addr[k])    addr_q[k] <= addr_val[k];
        else if (fire[k])   addr_q[k] <= addr_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
      vld_q    <= 1'b0;
      pkt_q    <= '0;
    end else begin
      if (any_fire) begin
        rr_ptr_q <= (grant_idx == IDX_BITS'(NUM_OUT_PORTS-1)) ? '0 : grant_idx + 1'b1;
        vld_q    <= 1'b1;
        pkt_q    <= pkt_d;
      end else if (slot_free) begin
        vld_q    <= 1'b0;
      end
    end
  end

  assign bus.o_packet       = pkt_q;
  assign bus.o_packet_valid = vld_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Bench for leaf_out_arbiter: table-driven round-robin vectors plus scripted
// corner sequences, with packets checked against an expected queue.
module tb_leaf_out_arbiter;
  import leaf_pkg::*;

  localparam int NP = DEF_NUM_OUT_PORTS;

  logic clk;
  logic reset_n;

  leaf_out_arbiter_if bus ();

  leaf_out_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int total = 0;
  int bad   = 0;
  logic [DEF_PACKET_BITS-1:0] exp_q[$];

  logic                         upd_fs_t   [NP];
  logic                         upd_addr_t [NP];
  logic                         add_t      [NP];
  logic [DEF_NUM_ADDR_BITS-1:0] fs_t       [NP];
  logic [DEF_NUM_ADDR_BITS-1:0] ba_t       [NP];
  logic [DEF_PAYLOAD_BITS-1:0]  data_t     [NP];
  logic [DEF_NUM_ADDR_BITS-1:0] m_addr     [NP];

  typedef struct {
    logic [NP-1:0] valid;
    logic [NP-1:0] exp_ready;
  } vec_t;
  vec_t tbl [12];

  function automatic logic [DEF_NUM_LEAF_BITS-1:0] leaf_of(int k);
    return DEF_NUM_LEAF_BITS'(k*5 + 3);
  endfunction

  function automatic logic [DEF_NUM_PORT_BITS-1:0] port_of(int k);
    return DEF_NUM_PORT_BITS'(k + 1);
  endfunction

  function automatic logic [DEF_PACKET_BITS-1:0] make_pkt(int k, logic [DEF_NUM_ADDR_BITS-1:0] a,
                                                          logic [DEF_PAYLOAD_BITS-1:0] d);
    logic [DEF_PACKET_BITS-1:0] p;
    p = '0;
    p[PKT_VALID_BIT]                         = 1'b1;
    p[PKT_LEAF_LSB +: DEF_NUM_LEAF_BITS]     = leaf_of(k);
    p[PKT_PORT_LSB +: DEF_NUM_PORT_BITS]     = port_of(k);
    p[PKT_ADDR_LSB +: DEF_NUM_ADDR_BITS]     = a;
    p[PKT_PAYLOAD_LSB +: DEF_PAYLOAD_BITS]   = d;
    return p;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_ctrl();
    logic [SLICE_BITS*NP-1:0] v;
    logic [DEF_PAYLOAD_BITS*NP-1:0] d;
    v = '0;
    d = '0;
    for (int k = 0; k < NP; k++) begin
      v[k*SLICE_BITS + SL_UPDF_BIT] = upd_fs_t[k];
      v[k*SLICE_BITS + SL_UPDA_BIT] = upd_addr_t[k];
      v[k*SLICE_BITS + SL_ADD_BIT]  = add_t[k];
      v[k*SLICE_BITS + SL_FS_LSB   +: DEF_NUM_ADDR_BITS] = fs_t[k];
      v[k*SLICE_BITS + SL_ADDR_LSB +: DEF_NUM_ADDR_BITS] = ba_t[k];
      v[k*SLICE_BITS + SL_PORT_LSB +: DEF_NUM_PORT_BITS] = port_of(k);
      v[k*SLICE_BITS + SL_LEAF_LSB +: DEF_NUM_LEAF_BITS] = leaf_of(k);
      d[k*DEF_PAYLOAD_BITS +: DEF_PAYLOAD_BITS] = data_t[k];
    end
    bus.i_out_ctrl = v;
    bus.i_data     = d;
  endtask

  task automatic clear_ctrl();
    for (int k = 0; k < NP; k++) begin
      upd_fs_t[k] = 1'b0; upd_addr_t[k] = 1'b0; add_t[k] = 1'b0;
    end
  endtask

  task automatic load(input int k, input logic do_fs, input logic [6:0] fs,
                      input logic do_ba, input logic [6:0] ba);
    upd_fs_t[k] = do_fs;   fs_t[k] = fs;
    upd_addr_t[k] = do_ba; ba_t[k] = ba;
  endtask

  // One cycle: called #1 after a rising edge with controls set; returns #1 after the next.
  task automatic step(input logic [NP-1:0] exp_ready, input string name);
    for (int k = 0; k < NP; k++) begin
      data_t[k] = {$urandom, $urandom};
      if (upd_addr_t[k]) m_addr[k] = ba_t[k];
    end
    drive_ctrl();
    #1;
    chk({name, "_ready"}, 128'(bus.o_ready), 128'(exp_ready));
    for (int k = 0; k < NP; k++) begin
      if (exp_ready[k]) begin
        exp_q.push_back(make_pkt(k, m_addr[k], data_t[k]));
        m_addr[k] = m_addr[k] + 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (exp_ready != '0) chk({name, "_latency"}, 128'(bus.o_packet_valid), 128'(1));
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n && bus.o_packet_valid && bus.i_packet_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pkt_unexpected actual=%0h required=none", bus.o_packet);
      end else begin
        chk("pkt", 128'(bus.o_packet), 128'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [DEF_PACKET_BITS-1:0] held;

    tbl[0]  = '{7'b0100101, 7'b0000001};
    tbl[1]  = '{7'b0100101, 7'b0000100};
    tbl[2]  = '{7'b0100101, 7'b0100000};
    tbl[3]  = '{7'b0100101, 7'b0000001};
    tbl[4]  = '{7'b0100101, 7'b0000100};
    tbl[5]  = '{7'b0100101, 7'b0100000};
    tbl[6]  = '{7'b0000100, 7'b0000100};
    tbl[7]  = '{7'b0100001, 7'b0100000};
    tbl[8]  = '{7'b0000101, 7'b0000001};
    tbl[9]  = '{7'b0000000, 7'b0000000};
    tbl[10] = '{7'b1000000, 7'b0000000};
    tbl[11] = '{7'b0100101, 7'b0000100};

    clear_ctrl();
    for (int k = 0; k < NP; k++) begin
      fs_t[k] = '0; ba_t[k] = '0; data_t[k] = '0; m_addr[k] = '0;
    end
    drive_ctrl();
    reset_n            = 1'b0;
    bus.i_valid        = '1;
    bus.i_packet_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid",  128'(bus.o_packet_valid), 128'(0));
    chk("reset_packet", 128'(bus.o_packet),       128'(0));
    chk("reset_ready",  128'(bus.o_ready),        128'(0));
    bus.i_valid = '0;
    reset_n     = 1'b1;

    // Round-robin over ports 0, 2, 5.
    load(0, 1'b1, 7'd10, 1'b0, 7'd0);
    load(2, 1'b1, 7'd10, 1'b0, 7'd0);
    load(5, 1'b1, 7'd10, 1'b0, 7'd0);
    step('0, "rr_load");
    clear_ctrl();
    for (int i = 0; i < 12; i++) begin
      bus.i_valid = tbl[i].valid;
      step(tbl[i].exp_ready, $sformatf("rr_vec%0d", i));
    end

    // Credit load and exhaustion on port 0; blocked in the reconfig cycle.
    bus.i_valid = 7'b0000001;
    load(0, 1'b1, 7'd3, 1'b1, 7'd20);
    step('0, "cl_pulse");
    clear_ctrl();
    repeat (3) step(7'b0000001, "cl_fire");
    repeat (3) step('0, "cl_empty");

    // Backpressure with a packet held on port 3.
    bus.i_valid = '0;
    load(3, 1'b1, 7'd10, 1'b1, 7'd50);
    step('0, "bp_load");
    clear_ctrl();
    bus.i_valid = 7'b0001000;
    step(7'b0001000, "bp_fire");
    bus.i_packet_ready = 1'b0;
    held = (exp_q.size() > 0) ? exp_q[0] : '0;
    for (int i = 0; i < 4; i++) begin
      step('0, "bp_stall");
      chk("bp_valid", 128'(bus.o_packet_valid), 128'(1));
      chk("bp_hold",  128'(bus.o_packet),       128'(held));
    end
    bus.i_packet_ready = 1'b1;
    step(7'b0001000, "bp_release");
    bus.i_valid = '0;
    step('0, "bp_drain");

    // Add and fire in the same cycle on port 1.
    load(1, 1'b1, 7'd1, 1'b1, 7'd0);
    step('0, "af_load");
    clear_ctrl();
    bus.i_valid = 7'b0000010;
    add_t[1] = 1'b1;
    step(7'b0000010, "af_both");
    bus.i_valid = '0;
    step('0, "af_add");
    clear_ctrl();
    bus.i_valid = 7'b0000010;
    step(7'b0000010, "af_use");
    step(7'b0000010, "af_use");
    step('0, "af_empty");

    // Address wrap and credit saturation on port 4.
    bus.i_valid = '0;
    load(4, 1'b1, 7'd127, 1'b1, 7'd126);
    step('0, "ws_load");
    clear_ctrl();
    add_t[4] = 1'b1;
    step('0, "ws_sat");
    clear_ctrl();
    bus.i_valid = 7'b0010000;
    repeat (3) step(7'b0010000, "ws_fire");

    // Reset with a packet held and credits outstanding.
    step(7'b0010000, "rst_prefire");
    bus.i_packet_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_ready",  128'(bus.o_ready),  128'(0));
    chk("rst_held_q", 128'(exp_q.size()), 128'(1));
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("rst_valid",  128'(bus.o_packet_valid), 128'(0));
    chk("rst_packet", 128'(bus.o_packet),       128'(0));
    reset_n = 1'b1;
    bus.i_packet_ready = 1'b1;
    bus.i_valid = '1;
    for (int k = 0; k < NP; k++) m_addr[k] = '0;
    repeat (3) step('0, "rst_nocredit");
    load(4, 1'b1, 7'd1, 1'b1, 7'd5);
    step('0, "rst_reload");
    clear_ctrl();
    step(7'b0010000, "rst_fire");
    step('0, "rst_empty");

    bus.i_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/leaf_out_arbiter.md
Name: leaf_out_arbiter

Overview:
- Schedules the output ports of one BFT leaf onto the leaf's single outbound packet stream.
- Per output port, it keeps a credit (freespace) counter and a remote BRAM write-address pointer. Both are driven by the update/add pulses and fields in the output-port slice of the leaf control-register word.
- A round-robin arbiter picks among ports that are valid and hold credit, then launches the formatted packet through a one-entry output register.

Parameters:
- PACKET_BITS, 97, width of a BFT packet.
- NUM_LEAF_BITS, 6, leaf-address width.
- NUM_PORT_BITS, 4, port-number width.
- NUM_ADDR_BITS, 7, BRAM address and freespace width.
- PAYLOAD_BITS, 64, data payload width.
- NUM_OUT_PORTS, 7, number of arbitrated output ports.
- OUT_PORTS_REG_BITS (localparam), NUM_LEAF_BITS+NUM_PORT_BITS+2*NUM_ADDR_BITS+3, width of one port's control slice.

Ports:
- clk  in  1  clock.
- reset_n  in  1  active-low synchronous reset.
- i_out_ctrl  in  OUT_PORTS_REG_BITS*NUM_OUT_PORTS  per-port slice k = {update_freespace_en, update_bram_addr_en, add_freespace_en, dst_leaf, dst_port, bram_addr, freespace}, MSB first.
- i_data  in  PAYLOAD_BITS*NUM_OUT_PORTS  port k payload at [PAYLOAD_BITS*(k+1)-1 : PAYLOAD_BITS*k].
- i_valid  in  NUM_OUT_PORTS  port k has a word.
- o_ready  out  NUM_OUT_PORTS  port k word consumed this cycle.
- o_packet  out  PACKET_BITS  formatted outbound packet.
- o_packet_valid  out  1  o_packet holds a packet.
- i_packet_ready  in  1  downstream accepts o_packet.

Behaviour:
- Reset (reset_n=0 at posedge):
  - all credits = 0, all address pointers = 0, RR pointer = 0.
  - o_packet_valid = 0, o_packet = 0.
  - o_ready is combinational and is 0 while reset_n=0.
- Credit counter per port, NUM_ADDR_BITS bits:
  - update_freespace_en: load the freespace field. This has top priority.
  - else add_freespace_en with fire: unchanged.
  - else add_freespace_en alone: +1, saturating at 2^NUM_ADDR_BITS-1.
  - else fire: -1.
- Address pointer per port:
  - update_bram_addr_en: load bram_addr.
  - else on fire: +1, modulo 2^NUM_ADDR_BITS (127 wraps to 0).
- Eligibility of port k: i_valid[k] && credit[k]!=0 && !update_freespace_en[k] && !update_bram_addr_en[k]. A port being reconfigured cannot fire in that cycle.
- Slot free when !o_packet_valid || i_packet_ready.
- Grant:
  - One-hot, combinational.
  - Picks the first eligible port scanning from RR pointer upward, modulo NUM_OUT_PORTS.
  - Asserted only when the slot is free.
- Fire and o_ready:
  - o_ready = grant; fire[k] = grant[k].
  - Handshake: a port word is consumed iff i_valid && o_ready in the same cycle.
- RR pointer after a fire on port k: (k+1) mod NUM_OUT_PORTS. Unchanged when no fire.
- Output register:
  - On fire, the next cycle has o_packet_valid=1 and o_packet formatted as below.
  - If the slot is free with no fire, o_packet_valid drops to 0.
  - While o_packet_valid && !i_packet_ready, o_packet is held stable.
- o_packet format:
  - [PACKET_BITS-1] = 1.
  - next NUM_LEAF_BITS = dst_leaf[k].
  - next NUM_PORT_BITS = dst_port[k].
  - [PAYLOAD_BITS+NUM_ADDR_BITS-1 : PAYLOAD_BITS] = the address pointer value before the increment.
  - [PAYLOAD_BITS-1:0] = payload.
  - all remaining bits = 0.
  - dst_leaf and dst_port are sampled in the fire cycle.
- Timing: latency i_valid to o_packet_valid is 1 cycle. Throughput is one packet per cycle when i_packet_ready stays high.
- Boundary conditions:
  - credit 0 blocks the port, even with i_valid high.
  - credit saturation: add at 127 stays 127.
  - reset mid-stream: a held o_packet is discarded, and no o_ready is asserted in the reset cycle.

Decomposition:
- Package leaf_pkg holds:
  - field offset/width constants for the per-port control slice.
  - o_packet field offsets (valid, leaf, port, addr, payload).
  - default widths shared with the control-register block.
- One sub-module, rr_arbiter: parameter N; inputs request vector and pointer; outputs one-hot grant and encoded index. Purely combinational.
- Credit counters, address pointers and the output register stay in leaf_out_arbiter.

Test Plan:
- Credit load and exhaustion: update_freespace_en pulse on port 0 with freespace=3, i_valid[0] held high, i_packet_ready=1.
  - Exactly 3 packets leave, with addr field bram_addr, +1, +2.
  - o_ready[0] then stays 0.
- Round-robin fairness: ports 0, 2, 5 loaded with credit 10 and all valid.
  - Grant order is 0,2,5,0,2,5.
  - o_packet leaf/port fields match each port's dst_leaf/dst_port.
- Backpressure: i_packet_ready=0 for 4 cycles with a packet held.
  - o_packet stays stable and o_ready stays all 0.
  - When ready rises, the next grant fires in that same cycle.
- Simultaneous add and fire: port 1 credit 1, add_freespace_en and fire in the same cycle.
  - Credit stays 1.
  - On the next cycle, with add_freespace_en alone and no fire, credit becomes 2.
- Wrap and saturation:
  - address pointer loaded to 126, two fires: addr fields 126, 127, next pointer 0.
  - credit at 127 plus add_freespace_en: stays 127.
- Reset mid-operation: reset_n=0 while o_packet_valid=1 and credits are nonzero.
  - Next cycle o_packet_valid=0 and all credits are 0.
  - No fire until a new update pulse arrives.
